// File: rtl/display_scan_driver.sv
// display_scan_driver: glyph buffer with 7-segment decode, scroll/blink
// and time-multiplexed scan of common-anode digits plus parallel frame.
module display_scan_driver #(
    parameter int N_DIGITS   = 4,
    parameter int BUF_DEPTH  = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 64,
    parameter int BLINK_DIV  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [4:0]                 wr_glyph,
    output logic                       full,
    output logic [$clog2(BUF_DEPTH):0] len,
    input  logic                       scroll_en,
    input  logic                       blink_en,
    output logic [6:0]                 seg,
    output logic [N_DIGITS-1:0]        an,
    output logic [7*N_DIGITS-1:0]      frame
);
    localparam int LW = $clog2(BUF_DEPTH) + 1;
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int PW = LW + 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int RW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] BLANK = 7'h7F;

    logic [4:0]            buf_q [BUF_DEPTH];
    logic [4:0]            buf_d [BUF_DEPTH];
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         off_q, off_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [RW-1:0]         scr_q, scr_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic                  phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7*N_DIGITS-1:0] frame_q, frame_d;
    logic [6:0]            win [N_DIGITS];
    logic [PW-1:0]         pos;
    logic                  full_w, wr_ok, tick, scrolling;

    function automatic logic [6:0] glyph_seg(input logic [4:0] g);
        logic [6:0] s;
        case (g)
            5'h00: s = 7'b0000001;
            5'h01: s = 7'b1001111;
            5'h02: s = 7'b0010010;
            5'h03: s = 7'b0000110;
            5'h04: s = 7'b1001100;
            5'h05: s = 7'b0100100;
            5'h06: s = 7'b0100000;
            5'h07: s = 7'b0001111;
            5'h08: s = 7'b0000000;
            5'h09: s = 7'b0000100;
            5'h0A: s = 7'b0001000;
            5'h0B: s = 7'b1100000;
            5'h0C: s = 7'b0110001;
            5'h0D: s = 7'b1000010;
            5'h0E: s = 7'b0110000;
            5'h0F: s = 7'b0111000;
            5'h11: s = 7'b1111110;
            5'h12: s = 7'b0011000;
            5'h13: s = 7'b1110001;
            5'h14: s = 7'b1100010;
            5'h15: s = 7'b1101010;
            5'h16: s = 7'b1111010;
            5'h17: s = 7'b1000001;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Append accepted glyphs; clear overrides any write in the same cycle.
    always_comb begin
        full_w = (len_q == LW'(BUF_DEPTH));
        wr_ok  = wr_en && !full_w && !clear;
        buf_d  = buf_q;
        len_d  = len_q;
        if (clear) begin
            len_d = '0;
        end else if (wr_ok) begin
            buf_d[len_q[AW-1:0]] = wr_glyph;
            len_d = len_q + LW'(1);
        end
    end

    // Digit dwell counter, digit index and the end-of-frame tick.
    always_comb begin
        cnt_d = cnt_q + SW'(1);
        dig_d = dig_q;
        tick  = 1'b0;
        if (cnt_q == SW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            if (dig_q == DW'(N_DIGITS - 1)) begin
                dig_d = '0;
                tick  = 1'b1;
            end else begin
                dig_d = dig_q + DW'(1);
            end
        end
    end

    // Scroll offset walks 0..len (the extra slot is the blank separator).
    always_comb begin
        scrolling = scroll_en && (len_q > LW'(N_DIGITS));
        off_d = off_q;
        scr_d = scr_q;
        if (clear || !scrolling) begin
            off_d = '0;
            scr_d = '0;
        end else if (tick) begin
            if (scr_q == RW'(SCROLL_DIV - 1)) begin
                scr_d = '0;
                off_d = (off_q == len_q) ? '0 : off_q + LW'(1);
            end else begin
                scr_d = scr_q + RW'(1);
            end
        end
    end

    // Blink phase: frame-counted toggle, held "on" while disabled.
    always_comb begin
        phase_d = phase_q;
        blk_d   = blk_q;
        if (!blink_en) begin
            phase_d = 1'b1;
            blk_d   = '0;
        end else if (tick) begin
            if (blk_q == BW'(BLINK_DIV - 1)) begin
                blk_d   = '0;
                phase_d = !phase_q;
            end else begin
                blk_d = blk_q + BW'(1);
            end
        end
    end

    // Visible window; short messages pad with blanks instead of wrapping.
    always_comb begin
        pos = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            pos = PW'(off_q) + PW'(i);
            if (len_q > LW'(N_DIGITS) && pos >= PW'(len_q) + PW'(1))
                pos = pos - (PW'(len_q) + PW'(1));
            if (pos >= PW'(len_q))
                win[i] = BLANK;
            else
                win[i] = glyph_seg(buf_q[pos[AW-1:0]]);
        end
    end

    // Next parallel frame and scanned digit drive.
    always_comb begin
        frame_d = '0;
        for (int i = 0; i < N_DIGITS; i++)
            frame_d[7*(N_DIGITS-1-i) +: 7] = win[i];
        if (phase_q) begin
            seg_d = win[dig_q];
            an_d  = ~(N_DIGITS'(1) << dig_q);
        end else begin
            seg_d = BLANK;
            an_d  = '1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
            len_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            scr_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b1;
            seg_q   <= BLANK;
            an_q    <= '1;
            frame_q <= '1;
        end else begin
            buf_q   <= buf_d;
            len_q   <= len_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            scr_q   <= scr_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign full  = full_w;
    assign len   = len_q;
    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: scenario tasks checked against a
// queue-based reference model of the display window and scan.
module tb_display_scan_driver;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int SD    = 4;
    localparam int SCR   = 1;
    localparam int BL    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    localparam logic [6:0] GTAB [24] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
        7'b1111111, 7'b1111110, 7'b0011000, 7'b1110001,
        7'b1100010, 7'b1101010, 7'b1111010, 7'b1000001
    };

    logic clk = 0;
    logic rst_n = 1;
    logic clear = 0;
    logic wr_en = 0;
    logic [4:0] wr_glyph = '0;
    logic scroll_en = 0;
    logic blink_en = 0;
    logic full;
    logic [LW-1:0] len;
    logic [6:0] seg;
    logic [N-1:0] an;
    logic [7*N-1:0] frame;

    int total = 0;
    int bad = 0;

    int mq[$];
    int moff, msc, mbc, e_off, e_len;
    bit mphase;
    longint mk;
    logic [6:0] e_seg;
    logic [N-1:0] e_an;
    logic [7*N-1:0] e_frame;

    display_scan_driver #(
        .N_DIGITS(N), .BUF_DEPTH(DEPTH), .SCAN_DIV(SD),
        .SCROLL_DIV(SCR), .BLINK_DIV(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_glyph(wr_glyph),
        .full(full), .len(len),
        .scroll_en(scroll_en), .blink_en(blink_en),
        .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(int g);
        if (g < 24) return GTAB[g];
        return 7'h7F;
    endfunction

    // Message followed by blanks; long messages rotate with a separator.
    function automatic logic [6:0] ref_digit(int i);
        int n, p;
        n = mq.size();
        if (n <= N) p = i;
        else p = (moff + i) % (n + 1);
        if (p >= n) return 7'h7F;
        return ref_glyph(mq[p]);
    endfunction

    task automatic model_reset();
        mq.delete();
        moff = 0; msc = 0; mbc = 0;
        mphase = 1; mk = 0;
        e_len = 0;
    endtask

    task automatic step();
        logic c, w, se, be;
        logic [4:0] g;
        int d, n;
        bit tick;
        c = clear; w = wr_en; se = scroll_en;
        be = blink_en; g = wr_glyph;
        for (int i = 0; i < N; i++)
            e_frame[7*(N-1-i) +: 7] = ref_digit(i);
        d = int'((mk / SD) % N);
        e_an = '1;
        if (mphase) begin
            e_an[d] = 1'b0;
            e_seg = ref_digit(d);
        end else begin
            e_seg = 7'h7F;
        end
        e_off = moff;
        tick = (mk % (N * SD)) == (N * SD - 1);
        n = mq.size();
        if (c || !(se && n > N)) begin
            moff = 0; msc = 0;
        end else if (tick) begin
            msc++;
            if (msc == SCR) begin
                msc = 0;
                moff = (moff + 1) % (n + 1);
            end
        end
        if (!be) begin
            mphase = 1; mbc = 0;
        end else if (tick) begin
            mbc++;
            if (mbc == BL) begin
                mbc = 0;
                mphase = !mphase;
            end
        end
        if (c) mq.delete();
        else if (w && n < DEPTH) mq.push_back(int'(g));
        mk++;
        e_len = mq.size();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        total += 4;
        if (seg !== 7'h7F) begin
            bad++; $display("FAIL rst_seg got=%b exp=1111111", seg);
        end
        if (an !== 4'hF) begin
            bad++; $display("FAIL rst_an got=%b exp=1111", an);
        end
        if (frame !== 28'hFFFFFFF) begin
            bad++; $display("FAIL rst_frame got=%h exp=fffffff", frame);
        end
        if (len !== 0 || full !== 0) begin
            bad++; $display("FAIL rst_len got=%0d/%b exp=0/0", len, full);
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        step();
        total++;
        if (an !== 4'b1110 || seg !== 7'h7F) begin
            bad++; $display("FAIL first_cycle got=%b/%b exp=1110/1111111", an, seg);
        end
    endtask

    task automatic test_static();
        logic [27:0] exp_f;
        exp_f = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        for (int g = 1; g <= 4; g++) begin
            wr_en = 1; wr_glyph = 5'(g);
            step();
            total++;
            if (len !== LW'(g)) begin
                bad++; $display("FAIL static_len got=%0d exp=%0d", len, g);
            end
        end
        wr_en = 0;
        for (int k = 0; k < 2 * N * SD; k++) begin
            step();
            total += 3;
            if (frame !== exp_f) begin
                bad++; $display("FAIL static_frame got=%h exp=%h", frame, exp_f);
            end
            if (an !== e_an) begin
                bad++; $display("FAIL static_an got=%b exp=%b", an, e_an);
            end
            if (seg !== e_seg) begin
                bad++; $display("FAIL static_seg got=%b exp=%b", seg, e_seg);
            end
        end
    endtask

    task automatic test_full_clear();
        clear = 1; step(); clear = 0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1; wr_glyph = 5'($urandom_range(0, 31));
            step();
        end
        total++;
        if (full !== 1 || len !== LW'(DEPTH)) begin
            bad++; $display("FAIL fill got=%0d/%b exp=8/1", len, full);
        end
        wr_glyph = 5'h05;
        step();
        total += 2;
        if (len !== LW'(DEPTH)) begin
            bad++; $display("FAIL over_write got=%0d exp=8", len);
        end
        if (frame !== e_frame) begin
            bad++; $display("FAIL full_frame got=%h exp=%h", frame, e_frame);
        end
        clear = 1; wr_en = 1;
        step();
        clear = 0; wr_en = 0;
        total++;
        if (len !== 0 || full !== 0) begin
            bad++; $display("FAIL clear_wr got=%0d/%b exp=0/0", len, full);
        end
        step();
        total++;
        if (frame !== 28'hFFFFFFF) begin
            bad++; $display("FAIL clear_frame got=%h exp=fffffff", frame);
        end
    endtask

    task automatic test_scroll();
        int seen;
        logic [4:0] msg [5];
        logic [27:0] f4, f0;
        msg = '{5'h12, 5'h13, 5'h0A, 5'h11, 5'h05};
        f4 = {7'b0100100, 7'b1111111, 7'b0011000, 7'b1110001};
        f0 = {7'b0011000, 7'b1110001, 7'b0001000, 7'b1111110};
        seen = 0;
        clear = 1; step(); clear = 0;
        for (int k = 0; k < 5; k++) begin
            wr_en = 1; wr_glyph = msg[k];
            step();
        end
        wr_en = 0; scroll_en = 1;
        for (int k = 0; k < 7 * N * SD; k++) begin
            step();
            total++;
            if (frame !== e_frame) begin
                bad++; $display("FAIL scroll_frame got=%h exp=%h", frame, e_frame);
            end
            if (e_off == 4) begin
                seen++;
                total++;
                if (frame !== f4) begin
                    bad++; $display("FAIL scroll_o4 got=%h exp=%h", frame, f4);
                end
            end
        end
        total++;
        if (seen == 0) begin
            bad++; $display("FAIL scroll_o4_seen got=0 exp>0");
        end
        scroll_en = 0;
        step(); step();
        total++;
        if (frame !== f0) begin
            bad++; $display("FAIL scroll_drop got=%h exp=%h", frame, f0);
        end
    endtask

    task automatic test_blink();
        logic [27:0] f0;
        int offc;
        f0 = {7'b0011000, 7'b1110001, 7'b0001000, 7'b1111110};
        offc = 0;
        blink_en = 1;
        for (int k = 0; k < 8 * N * SD; k++) begin
            step();
            total += 3;
            if (an === 4'hF) offc++;
            if (frame !== f0) begin
                bad++; $display("FAIL blink_frame got=%h exp=%h", frame, f0);
            end
            if (an !== e_an) begin
                bad++; $display("FAIL blink_an got=%b exp=%b", an, e_an);
            end
            if (seg !== e_seg) begin
                bad++; $display("FAIL blink_seg got=%b exp=%b", seg, e_seg);
            end
        end
        total++;
        if (offc < 3 * N * SD) begin
            bad++; $display("FAIL blink_off_cycles got=%0d exp>=%0d", offc, 3 * N * SD);
        end
        blink_en = 0;
    endtask

    task automatic test_short();
        logic [27:0] fs;
        fs = {7'b0110000, 7'h7F, 7'h7F, 7'h7F};
        clear = 1; step(); clear = 0;
        wr_en = 1; wr_glyph = 5'h0E;
        step();
        wr_en = 0; scroll_en = 1;
        for (int k = 0; k < 3 * N * SD; k++) begin
            step();
            total++;
            if (frame !== fs) begin
                bad++; $display("FAIL short_frame got=%h exp=%h", frame, fs);
            end
        end
        scroll_en = 0;
    endtask

    task automatic test_random();
        scroll_en = 1;
        for (int k = 0; k < 1500; k++) begin
            wr_en = ($urandom_range(0, 99) < 30);
            wr_glyph = 5'($urandom_range(0, 31));
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) scroll_en = ~scroll_en;
            if ($urandom_range(0, 149) == 0) blink_en = ~blink_en;
            step();
            total += 5;
            if (frame !== e_frame) begin
                bad++; $display("FAIL rand_frame cyc=%0d got=%h exp=%h", k, frame, e_frame);
            end
            if (an !== e_an) begin
                bad++; $display("FAIL rand_an cyc=%0d got=%b exp=%b", k, an, e_an);
            end
            if (seg !== e_seg) begin
                bad++; $display("FAIL rand_seg cyc=%0d got=%b exp=%b", k, seg, e_seg);
            end
            if (len !== LW'(e_len)) begin
                bad++; $display("FAIL rand_len cyc=%0d got=%0d exp=%0d", k, len, e_len);
            end
            if (full !== (e_len == DEPTH)) begin
                bad++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", k, full, e_len == DEPTH);
            end
        end
        clear = 0; wr_en = 0;
    endtask

    task automatic test_async_reset();
        clear = 1; step(); clear = 0;
        for (int k = 0; k < 6; k++) begin
            wr_en = 1; wr_glyph = 5'(k + 1);
            step();
        end
        wr_en = 0; scroll_en = 1; blink_en = 1;
        for (int k = 0; k < 45; k++) step();
        #2 rst_n = 0;
        #1;
        total += 3;
        if (seg !== 7'h7F || an !== 4'hF) begin
            bad++; $display("FAIL arst_drive got=%b/%b exp=1111111/1111", seg, an);
        end
        if (frame !== 28'hFFFFFFF) begin
            bad++; $display("FAIL arst_frame got=%h exp=fffffff", frame);
        end
        if (len !== 0 || full !== 0) begin
            bad++; $display("FAIL arst_len got=%0d/%b exp=0/0", len, full);
        end
        scroll_en = 0; blink_en = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        for (int k = 0; k < 2 * N * SD; k++) begin
            step();
            total += 2;
            if (an !== e_an || seg !== e_seg) begin
                bad++; $display("FAIL arst_scan got=%b/%b exp=%b/%b", an, seg, e_an, e_seg);
            end
            if (frame !== e_frame) begin
                bad++; $display("FAIL arst_post_frame got=%h exp=%h", frame, e_frame);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_full_clear();
        test_scroll();
        test_blink();
        test_short();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
